// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding, instruction opcodes and IR capture value.
package jtag_pkg;
  localparam int IR_WIDTH = 4;
  localparam logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'b0001;
  localparam logic [IR_WIDTH-1:0] BYPASS_INSTR = 4'b1111;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0001;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR,
    UPDATE_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_t;
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller next-state logic and state register.
// Ports: clk/reset (sync, active-high), tms; state = current, next_state = decode of tms.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t next_state
);
  always_comb begin
    next_state = TLR;
    case (state)
      TLR:       next_state = tms ? TLR : RTI;
      RTI:       next_state = tms ? SEL_DR : RTI;
      SEL_DR:    next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR:    next_state = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:  next_state = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:  next_state = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:  next_state = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:  next_state = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR: next_state = tms ? SEL_DR : RTI;
      SEL_IR:    next_state = tms ? TLR : CAP_IR;
      CAP_IR:    next_state = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:  next_state = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:  next_state = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:  next_state = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:  next_state = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR: next_state = tms ? SEL_DR : RTI;
      default:   next_state = TLR;
    endcase
  end
  always_ff @(posedge clk)
    state <= reset ? TLR : next_state;
endmodule

// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller: TAP controller with IR, bypass register and IDCODE transmitter control.
// Ports: clk/reset (sync, active-high), tms/tdi serial inputs, tx_out from the word transmitter;
// tx_enable/tx_reset drive the transmitter, tdo/tdo_en serial output, ir and state for debug.
module jtag_tap_controller #(
  parameter int                  IR_WIDTH     = jtag_pkg::IR_WIDTH,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = jtag_pkg::IDCODE_INSTR,
  parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = jtag_pkg::BYPASS_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tms,
  input  logic                tdi,
  input  logic                tx_out,
  output logic                tx_enable,
  output logic                tx_reset,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir,
  output logic [3:0]          state
);
  import jtag_pkg::*;
  tap_state_t cur, nxt;
  logic [IR_WIDTH-1:0] ir_shift;
  logic bypass_reg, sel_idcode;
  jtag_tap_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .tms        (tms),
    .state      (cur),
    .next_state (nxt)
  );
  // ir falls back to IDCODE on the same edge that enters TLR, whatever path led there
  always_ff @(posedge clk) begin
    if (reset) begin
      ir         <= IDCODE_INSTR;
      ir_shift   <= '0;
      bypass_reg <= 1'b0;
    end else begin
      ir_shift   <= cur == CAP_IR ? IR_WIDTH'(IR_CAPTURE) :
                    cur == SHIFT_IR ? {tdi, ir_shift[IR_WIDTH-1:1]} : ir_shift;
      bypass_reg <= cur == CAP_DR ? 1'b0 : cur == SHIFT_DR ? tdi : bypass_reg;
      ir         <= nxt == TLR ? IDCODE_INSTR : cur == UPDATE_IR ? ir_shift : ir;
    end
  end
  // every opcode other than IDCODE (known or not) routes through bypass
  assign sel_idcode = ir == IDCODE_INSTR && ir != BYPASS_INSTR;
  assign state      = cur;
  assign tx_enable  = cur == SHIFT_DR && sel_idcode;
  assign tx_reset   = cur == TLR || (cur == CAP_DR && sel_idcode);
  assign tdo_en     = cur == SHIFT_DR || cur == SHIFT_IR;
  assign tdo        = cur == SHIFT_IR ? ir_shift[0] :
                      cur == SHIFT_DR ? (sel_idcode ? tx_out : bypass_reg) : 1'b0;
endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb_jtag_tap_controller: scoreboard bench for the TAP controller against a table-driven model.
module tb_jtag_tap_controller;
  logic clk = 1'b0;
  logic reset, tms, tdi, tx_out;
  logic tx_enable, tx_reset, tdo, tdo_en;
  logic [3:0] ir, state;
  int n_chk = 0, n_fail = 0;
  int d_en = 0, d_rs = 0;

  jtag_tap_controller dut (
    .clk       (clk),
    .reset     (reset),
    .tms       (tms),
    .tdi       (tdi),
    .tx_out    (tx_out),
    .tx_enable (tx_enable),
    .tx_reset  (tx_reset),
    .tdo       (tdo),
    .tdo_en    (tdo_en),
    .ir        (ir),
    .state     (state)
  );

  always #5 clk = ~clk;

  localparam int S_TLR = 0, S_CAPDR = 3, S_SHDR = 4, S_CAPIR = 10, S_SHIR = 11, S_UPIR = 15;
  // transition tables indexed by state number: successor for tms=0 and tms=1
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int m_st = S_TLR;
  logic [3:0] m_ir = 4'b0001, m_sh = 4'b0000;
  logic m_byp = 1'b0;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] ir;
    logic en, rs, tdo, tden;
  } exp_t;
  exp_t q[$];

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
    end
  endtask

  // called at posedge+1: count what the DUT presents, drive, predict, then advance the model
  task automatic step(input logic t, input logic d, input logic r);
    exp_t e;
    logic idc;
    int nx;
    if (tx_enable === 1'b1) d_en++;
    if (tx_reset === 1'b1) d_rs++;
    tms = t; tdi = d; reset = r; tx_out = 1'($urandom_range(0, 1));
    idc = m_ir == 4'b0001;
    e.st   = 4'(m_st);
    e.ir   = m_ir;
    e.tden = m_st == S_SHDR || m_st == S_SHIR;
    e.en   = m_st == S_SHDR && idc;
    e.rs   = m_st == S_TLR || (m_st == S_CAPDR && idc);
    e.tdo  = m_st == S_SHIR ? m_sh[0] : m_st == S_SHDR ? (idc ? tx_out : m_byp) : 1'b0;
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      m_st = S_TLR; m_ir = 4'b0001; m_sh = 4'b0000; m_byp = 1'b0;
    end else begin
      nx = t ? nxt1[m_st] : nxt0[m_st];
      if (m_st == S_CAPIR) m_sh = 4'b0001;
      else if (m_st == S_SHIR) m_sh = (m_sh >> 1) | ({3'b000, d} << 3);
      if (m_st == S_CAPDR) m_byp = 1'b0;
      else if (m_st == S_SHDR) m_byp = d;
      if (nx == S_TLR) m_ir = 4'b0001;
      else if (m_st == S_UPIR) m_ir = m_sh;
      m_st = nx;
    end
    #1;
  endtask

  task automatic go_tlr();
    repeat (5) step(1'b1, 1'($urandom), 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] op);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, op[i], 0);
    step(1, 0, 0); step(0, 0, 0);
  endtask

  // from RTI: shift n1 bits, optionally pause np cycles and shift n2 more, back to RTI
  task automatic dr_scan(input int n1, input int np, input int n2, input logic [31:0] data);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < n1; i++) step(i == n1 - 1, data[i], 0);
    if (np > 0) begin
      step(0, 0, 0);
      for (int i = 0; i < np; i++) step(i == np - 1, 0, 0);
      step(0, 0, 0);
      for (int i = 0; i < n2; i++) step(i == n2 - 1, data[(n1 + i) % 32], 0);
    end
    step(1, 0, 0); step(0, 0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state", {28'd0, state}, {28'd0, e.st});
        check("ir", {28'd0, ir}, {28'd0, e.ir});
        check("tx_enable", {31'd0, tx_enable}, {31'd0, e.en});
        check("tx_reset", {31'd0, tx_reset}, {31'd0, e.rs});
        check("tdo", {31'd0, tdo}, {31'd0, e.tdo});
        check("tdo_en", {31'd0, tdo_en}, {31'd0, e.tden});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, r0;
    reset = 1'b1; tms = 1'b1; tdi = 1'b0; tx_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
    go_tlr();
    check("tlr_state", {28'd0, state}, 32'd0);
    check("tlr_ir", {28'd0, ir}, 32'd1);
    check("tlr_tx_reset", {31'd0, tx_reset}, 32'd1);
    check("tlr_tdo_en", {31'd0, tdo_en}, 32'd0);
    step(0, 0, 0);
    e0 = d_en; r0 = d_rs;
    dr_scan(32, 0, 0, $urandom);
    check("idcode_en_cycles", d_en - e0, 32);
    check("idcode_reset_pulses", d_rs - r0, 1);
    e0 = d_en; r0 = d_rs;
    dr_scan(10, 3, 22, $urandom);
    check("pause_en_cycles", d_en - e0, 32);
    check("pause_reset_pulses", d_rs - r0, 1);
    load_ir(4'b1111);
    check("ir_bypass", {28'd0, ir}, 32'hF);
    dr_scan(4, 0, 0, 32'b1101);
    load_ir(4'b0110);
    check("ir_unknown", {28'd0, ir}, 32'h6);
    e0 = d_en;
    dr_scan(8, 0, 0, $urandom);
    check("unknown_en_cycles", d_en - e0, 0);
    load_ir(4'b1111);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 1, 0);
    step(0, 0, 1);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_ir", {28'd0, ir}, 32'd1);
    check("rst_tx_enable", {31'd0, tx_enable}, 32'd0);
    step(0, 0, 0);
    repeat (20) begin
      load_ir(4'($urandom));
      dr_scan($urandom_range(1, 16), $urandom_range(0, 3), $urandom_range(1, 16), $urandom);
    end
    repeat (1500) step(1'($urandom), 1'($urandom), $urandom_range(0, 63) == 0);
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
